// File: rtl/matrix_add_pkg.sv
// Shared constants, types and helpers for the 4x4 matrix adder.
//   ELEM_W  element width in bits
//   N_ELEM  elements per matrix (4x4)
//   OUT_W   width of the packed result word
//   elem_t  one matrix element
//   elem_idx(row, col) -> row-major element index
package matrix_add_pkg;

    localparam int unsigned ELEM_W  = 16;
    localparam int unsigned N_ELEM  = 16;
    localparam int unsigned MAT_DIM = 4;
    localparam int unsigned OUT_W   = ELEM_W * N_ELEM;

    typedef logic [ELEM_W-1:0] elem_t;

    function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col);
        return MAT_DIM * row + col;
    endfunction

endpackage

// File: rtl/matrix_elem_add.sv
// Combinational adder for one matrix element.
// Ports:
//   a, b   in   element operands
//   sum    out  16-bit result (wrapped, or saturated when MATRIX_ADD_SAT_EN is defined)
//   carry  out  carry-out of the 17-bit sum, reported in both builds
// Optional feature: define MATRIX_ADD_SAT_EN to clamp overflowing sums to 0xFFFF.
module matrix_elem_add
    import matrix_add_pkg::*;
(
    input  elem_t a,
    input  elem_t b,
    output elem_t sum,
    output logic  carry
);

    logic [ELEM_W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        carry    = full_sum[ELEM_W];
`ifdef MATRIX_ADD_SAT_EN
        sum      = full_sum[ELEM_W] ? '1 : full_sum[ELEM_W-1:0];
`else
        sum      = full_sum[ELEM_W-1:0];
`endif
    end

endmodule

// File: rtl/matrix_adder_16.sv
// Element-wise adder for two 4x4 matrices of 16-bit unsigned elements, registered output.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   a1..a32 carry a valid operand set this cycle
//   a1..a16    in   matrix A, row-major
//   a17..a32   in   matrix B, row-major
//   out        out  16 sums, element k at out[16k+15:16k]
//   out_valid  out  out/ovf were captured on the previous edge
//   ovf        out  per-element carry-out
// Optional feature: MATRIX_ADD_SAT_EN (handled inside matrix_elem_add) selects saturation.
module matrix_adder_16
    import matrix_add_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] a1,  a2,  a3,  a4,  a5,  a6,  a7,  a8,
    input  logic [ELEM_W-1:0] a9,  a10, a11, a12, a13, a14, a15, a16,
    input  logic [ELEM_W-1:0] a17, a18, a19, a20, a21, a22, a23, a24,
    input  logic [ELEM_W-1:0] a25, a26, a27, a28, a29, a30, a31, a32,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic [N_ELEM-1:0] ovf
);

    elem_t              a_arr   [N_ELEM];
    elem_t              b_arr   [N_ELEM];
    elem_t              sum_arr [N_ELEM];
    logic  [N_ELEM-1:0] carry_vec;

    logic [OUT_W-1:0]  out_d, out_q;
    logic [N_ELEM-1:0] ovf_d, ovf_q;
    logic              out_valid_d, out_valid_q;

    assign a_arr[0]  = a1;  assign a_arr[1]  = a2;  assign a_arr[2]  = a3;  assign a_arr[3]  = a4;
    assign a_arr[4]  = a5;  assign a_arr[5]  = a6;  assign a_arr[6]  = a7;  assign a_arr[7]  = a8;
    assign a_arr[8]  = a9;  assign a_arr[9]  = a10; assign a_arr[10] = a11; assign a_arr[11] = a12;
    assign a_arr[12] = a13; assign a_arr[13] = a14; assign a_arr[14] = a15; assign a_arr[15] = a16;
    assign b_arr[0]  = a17; assign b_arr[1]  = a18; assign b_arr[2]  = a19; assign b_arr[3]  = a20;
    assign b_arr[4]  = a21; assign b_arr[5]  = a22; assign b_arr[6]  = a23; assign b_arr[7]  = a24;
    assign b_arr[8]  = a25; assign b_arr[9]  = a26; assign b_arr[10] = a27; assign b_arr[11] = a28;
    assign b_arr[12] = a29; assign b_arr[13] = a30; assign b_arr[14] = a31; assign b_arr[15] = a32;

    for (genvar r = 0; r < MAT_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAT_DIM; c++) begin : g_col
            localparam int unsigned K = elem_idx(r, c);
            matrix_elem_add u_elem_add (
                .a     (a_arr[K]),
                .b     (b_arr[K]),
                .sum   (sum_arr[K]),
                .carry (carry_vec[K])
            );
        end
    end

    // Results only move on a valid set; otherwise the last result is held.
    always_comb begin
        out_d       = out_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            for (int k = 0; k < N_ELEM; k++) begin
                out_d[ELEM_W*k +: ELEM_W] = sum_arr[k];
            end
            ovf_d = carry_vec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_adder_16.sv
// Scoreboard bench for matrix_adder_16: stimulus pushes expected results, a monitor pops them.
module tb_matrix_adder_16;

    typedef struct packed {
        logic [255:0] out;
        logic [15:0]  ovf;
    } resp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [15:0]  a_in [32];
    logic [255:0] out;
    logic         out_valid;
    logic [15:0]  ovf;

    resp_t        exp_q [$];
    resp_t        mon_exp;
    resp_t        basic_exp;
    int unsigned  n_vec = 0;
    int unsigned  n_bad = 0;

    always #5 clk = ~clk;

    matrix_adder_16 u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .a1  (a_in[0]),  .a2  (a_in[1]),  .a3  (a_in[2]),  .a4  (a_in[3]),
        .a5  (a_in[4]),  .a6  (a_in[5]),  .a7  (a_in[6]),  .a8  (a_in[7]),
        .a9  (a_in[8]),  .a10 (a_in[9]),  .a11 (a_in[10]), .a12 (a_in[11]),
        .a13 (a_in[12]), .a14 (a_in[13]), .a15 (a_in[14]), .a16 (a_in[15]),
        .a17 (a_in[16]), .a18 (a_in[17]), .a19 (a_in[18]), .a20 (a_in[19]),
        .a21 (a_in[20]), .a22 (a_in[21]), .a23 (a_in[22]), .a24 (a_in[23]),
        .a25 (a_in[24]), .a26 (a_in[25]), .a27 (a_in[26]), .a28 (a_in[27]),
        .a29 (a_in[28]), .a30 (a_in[29]), .a31 (a_in[30]), .a32 (a_in[31]),
        .out       (out),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [272:0] act, input logic [272:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: plain integer addition per element, then wrap or clamp.
    function automatic resp_t model();
        resp_t       r;
        int unsigned s;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            s = int'(a_in[k]) + int'(a_in[k+16]);
            r.ovf[k] = (s > 65535);
`ifdef MATRIX_ADD_SAT_EN
            r.out[16*k +: 16] = (s > 65535) ? 16'hFFFF : 16'(s);
`else
            r.out[16*k +: 16] = 16'(s % 65536);
`endif
        end
        return r;
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 32; i++) a_in[i] = 16'($urandom);
    endtask

    // Operands biased towards the 0 / 1 / 0xFFFF corners.
    task automatic corner_inputs();
        for (int i = 0; i < 32; i++) begin
            case ($urandom_range(0, 3))
                0:       a_in[i] = 16'h0000;
                1:       a_in[i] = 16'h0001;
                2:       a_in[i] = 16'hFFFF;
                default: a_in[i] = 16'($urandom);
            endcase
        end
    endtask

    task automatic issue();
        in_valid = 1'b1;
        exp_q.push_back(model());
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 required 0");
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {1'b0, out, ovf}, {1'b0, mon_exp.out, mon_exp.ovf});
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        randomize_inputs();

        // Reset holds everything at zero regardless of inputs.
        repeat (4) begin
            @(posedge clk); #1;
            randomize_inputs();
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_state", {out_valid, ovf, out}, '0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;

        // Basic pattern, then an idle cycle that must hold the result.
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            a_in[i]    = 16'(i + 1);
            a_in[i+16] = 16'h0100;
        end
        issue();
        for (int k = 0; k < 16; k++) basic_exp.out[16*k +: 16] = 16'(16'h0101 + k);
        basic_exp.ovf = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        randomize_inputs();
        @(posedge clk);
        @(negedge clk);
        check("idle_out_valid", {272'd0, out_valid}, '0);
        check("idle_hold", {1'b0, out, ovf}, {1'b0, basic_exp.out, basic_exp.ovf});

        // Overflow boundaries: 0xFFFF+0x0001 and 0xFFFF+0xFFFF.
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            a_in[i]    = 16'hFFFF;
            a_in[i+16] = 16'h0001;
        end
        issue();
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) a_in[i] = 16'hFFFF;
        issue();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Eight back-to-back random sets.
        for (int n = 0; n < 8; n++) begin
            randomize_inputs();
            issue();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Lane isolation.
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) a_in[i] = 16'h0000;
        a_in[4]  = 16'h1234;
        a_in[20] = 16'h4321;
        issue();

        // Corner-biased sets with random gaps.
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            corner_inputs();
            if ($urandom_range(0, 2) != 0) issue();
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Async reset mid-stream: X is presented, Y is dropped by the reset.
        @(posedge clk); #1;
        randomize_inputs();
        issue();
        @(posedge clk); #1;
        randomize_inputs();
        issue();
        @(negedge clk); #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_clear", {out_valid, ovf, out}, '0);
        @(posedge clk); #1;
        randomize_inputs();
        in_valid = 1'b1;
        @(negedge clk);
        check("reset_held", {out_valid, ovf, out}, '0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk); #1;
        randomize_inputs();
        issue();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("pending_results", {241'd0, 32'(exp_q.size())}, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
